// File: rtl/pipe_hdu.sv
// Hazard detection and forwarding unit for the hxd32 5-stage pipeline.
// Shadows the EX and MEM destinations. It produces the load-use stall, the redirect flush and the EX-aligned forward selects.
module pipe_hdu #(
    parameter int CNT_W = 16
) (
    input  logic             clk_i,
    input  logic             rst_n_i,
    input  logic             hold_i,
    input  logic             redirect_i,
    input  logic             rd_wr_en_i,
    input  logic [1:0]       rd_wr_sel_i,
    input  logic [4:0]       rd_wr_addr_i,
    input  logic             rs1_rd_en_i,
    input  logic             rs2_rd_en_i,
    input  logic [4:0]       rs1_rd_addr_i,
    input  logic [4:0]       rs2_rd_addr_i,
    output logic             stall_o,
    output logic             flush_o,
    output logic [1:0]       rs1_fwd_sel_o,
    output logic [1:0]       rs2_fwd_sel_o,
    output logic [CNT_W-1:0] stall_cnt_o
);

    localparam logic [1:0] FWD_RF  = 2'b00;
    localparam logic [1:0] FWD_MEM = 2'b01;
    localparam logic [1:0] FWD_WB  = 2'b10;

    // The WB result reaches ID through regfile write-through, so the retiring
    // slot is never consulted. The load flag only matters while in EX.
    logic             ex_en_q, ex_en_d;
    logic [4:0]       ex_addr_q, ex_addr_d;
    logic             ex_load_q, ex_load_d;
    logic             mem_en_q, mem_en_d;
    logic [4:0]       mem_addr_q, mem_addr_d;
    logic [1:0]       rs1_fwd_q, rs1_fwd_d;
    logic [1:0]       rs2_fwd_q, rs2_fwd_d;
    logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;

    logic rs1_ex_hit, rs2_ex_hit, rs1_mem_hit, rs2_mem_hit, bubble;

    function automatic logic hit(input logic rd_en, input logic [4:0] rs,
                                 input logic s_en, input logic [4:0] s_addr);
        return rd_en && (rs != 5'd0) && s_en && (s_addr != 5'd0) && (s_addr == rs);
    endfunction

    always_comb begin
        rs1_ex_hit  = hit(rs1_rd_en_i, rs1_rd_addr_i, ex_en_q, ex_addr_q);
        rs2_ex_hit  = hit(rs2_rd_en_i, rs2_rd_addr_i, ex_en_q, ex_addr_q);
        rs1_mem_hit = hit(rs1_rd_en_i, rs1_rd_addr_i, mem_en_q, mem_addr_q);
        rs2_mem_hit = hit(rs2_rd_en_i, rs2_rd_addr_i, mem_en_q, mem_addr_q);

        // Redirect wins over stall; both are suppressed while reset is low.
        stall_o = rst_n_i && !redirect_i && ex_load_q && (rs1_ex_hit || rs2_ex_hit);
        flush_o = rst_n_i && redirect_i;
        bubble  = stall_o || flush_o;

        ex_en_d     = ex_en_q;
        ex_addr_d   = ex_addr_q;
        ex_load_d   = ex_load_q;
        mem_en_d    = mem_en_q;
        mem_addr_d  = mem_addr_q;
        rs1_fwd_d   = rs1_fwd_q;
        rs2_fwd_d   = rs2_fwd_q;
        stall_cnt_d = stall_cnt_q;

        if (!hold_i) begin
            mem_en_d   = ex_en_q;
            mem_addr_d = ex_addr_q;
            if (bubble) begin
                ex_en_d   = 1'b0;
                ex_addr_d = 5'd0;
                ex_load_d = 1'b0;
                rs1_fwd_d = FWD_RF;
                rs2_fwd_d = FWD_RF;
            end else begin
                ex_en_d   = rd_wr_en_i;
                ex_addr_d = rd_wr_addr_i;
                ex_load_d = (rd_wr_sel_i == 2'b01);
                // Nearest producer wins: EX-slot result sits in MEM next cycle.
                rs1_fwd_d = rs1_ex_hit ? FWD_MEM : (rs1_mem_hit ? FWD_WB : FWD_RF);
                rs2_fwd_d = rs2_ex_hit ? FWD_MEM : (rs2_mem_hit ? FWD_WB : FWD_RF);
            end
            if (stall_o && (stall_cnt_q != {CNT_W{1'b1}}))
                stall_cnt_d = stall_cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            ex_en_q     <= 1'b0;
            ex_addr_q   <= 5'd0;
            ex_load_q   <= 1'b0;
            mem_en_q    <= 1'b0;
            mem_addr_q  <= 5'd0;
            rs1_fwd_q   <= FWD_RF;
            rs2_fwd_q   <= FWD_RF;
            stall_cnt_q <= '0;
        end else begin
            ex_en_q     <= ex_en_d;
            ex_addr_q   <= ex_addr_d;
            ex_load_q   <= ex_load_d;
            mem_en_q    <= mem_en_d;
            mem_addr_q  <= mem_addr_d;
            rs1_fwd_q   <= rs1_fwd_d;
            rs2_fwd_q   <= rs2_fwd_d;
            stall_cnt_q <= stall_cnt_d;
        end
    end

    assign rs1_fwd_sel_o = rs1_fwd_q;
    assign rs2_fwd_sel_o = rs2_fwd_q;
    assign stall_cnt_o   = stall_cnt_q;

endmodule

// File: doc/pipe_hdu.md
Name: pipe_hdu

Overview:
- Hazard detection and forwarding unit for the 5-stage hxd32 pipeline (IF, ID, EX, MEM, WB).
- Observes the decoded ID-stage instruction (the same signals the ID/EX register samples) and keeps its own shadow of the EX, MEM and WB destination registers.
- Drives back toward fetch/decode:
  - stall, to hold IF/ID and inject a bubble on load-use;
  - flush, to kill the wrong-path ID instruction on a redirect;
  - registered operand-forwarding selects, aligned to the EX stage.

Parameters:
- CNT_W, 16, width of the saturating stall-cycle performance counter.

Ports:
- clk_i  input  1  clock
- rst_n_i  input  1  reset, asynchronous, active-low
- hold_i  input  1  global pipeline freeze (DRAM wait); tracker does not advance
- redirect_i  input  1  taken branch/jump resolved in EX this cycle
- rd_wr_en_i  input  1  ID instruction writes rd
- rd_wr_sel_i  input  2  ID rd source: 00 ALU, 01 DRAM load, 10 PC link, 11 reserved (treated as ALU)
- rd_wr_addr_i  input  5  ID destination register
- rs1_rd_en_i  input  1  ID instruction reads rs1
- rs2_rd_en_i  input  1  ID instruction reads rs2
- rs1_rd_addr_i  input  5  ID rs1 address
- rs2_rd_addr_i  input  5  ID rs2 address
- stall_o  output  1  hold PC and IF/ID, bubble into ID/EX (combinational)
- flush_o  output  1  squash ID instruction into ID/EX bubble (combinational)
- rs1_fwd_sel_o  output  2  EX operand A source: 00 regfile, 01 MEM-stage result, 10 WB-stage result
- rs2_fwd_sel_o  output  2  same, for operand B
- stall_cnt_o  output  CNT_W  count of load-use stall cycles, saturating

Behaviour:
- Clock/reset: clk_i is the single clock; rst_n_i asynchronous active-low.
- Reset values:
  - All shadow slots (EX, MEM, WB) invalid: en=0, addr=0, load=0.
  - rs1_fwd_sel_o = rs2_fwd_sel_o = 2'b00.
  - stall_cnt_o = 0.
  - stall_o and flush_o evaluate to 0 (no slot valid, redirect ignored during reset).
- Slot validity: a slot is valid only if en=1 and addr != 0. x0 never causes a stall or a forward.
- Match definition: rsN in ID matches slot S if rsN_rd_en_i=1, rsN_rd_addr_i != 0, S valid, and S.addr == rsN_rd_addr_i.
- Load-use stall (combinational):
  - stall_o = !redirect_i && EX slot is a load && (rs1 matches EX || rs2 matches EX).
  - Lasts exactly one cycle: after the bubble, the load sits in MEM and is forwarded from WB.
- Flush (combinational): flush_o = redirect_i. Redirect has priority over stall, so stall_o=0 whenever redirect_i=1.
- Advance (posedge, when hold_i=0):
  - WB <= MEM; MEM <= EX.
  - EX <= bubble if stall_o or flush_o; otherwise EX <= {rd_wr_en_i, rd_wr_addr_i, rd_wr_sel_i==01}.
- Forward select (registered, same enable as advance; evaluated against pre-edge slots, nearest stage wins):
  - rsN matches EX -> 01 (result is in MEM when the consumer is in EX).
  - else rsN matches MEM -> 10.
  - else -> 00.
  - On stall_o or flush_o the selects are forced to 00 (bubble).
- hold_i=1:
  - All slots, forward selects and the counter hold their values.
  - stall_o/flush_o still evaluate combinationally; the pipeline ignores them while held.
- Regfile write-through: same-cycle WB write and ID read is resolved by regfile write-through. This block never forwards from the retiring WB slot.
- Counter: increments by 1 on each posedge with hold_i=0 and stall_o=1; saturates at all-ones (no wrap).
- Reset mid-operation: all slots clear immediately (async) and no stale forward survives.

Test Plan:
- Back-to-back ALU RAW: `add x5` then `sub x6,x5,x1` -> stall_o=0; next cycle rs1_fwd_sel_o=01, rs2_fwd_sel_o=00.
- Distance-2 RAW: `add x5`, `nop`, `or x7,x5,x5` -> both selects 10 when `or` is in EX; distance-3 -> 00.
- Load-use: `lw x8` then `add x9,x8,x2` -> stall_o=1 for exactly 1 cycle; EX slot bubble; then rs1_fwd_sel_o=10; stall_cnt_o 0->1.
- Redirect priority: redirect_i=1 while ID is load-use dependent -> flush_o=1, stall_o=0, selects 00, counter unchanged.
- x0 and unused operands: `addi x0` then reader of x0, and an I-type with rs2_rd_en_i=0 whose rs2 field equals a pending rd -> no stall, selects 00.
- hold and reset: hold_i=1 for 3 cycles mid-dependency -> selects and slots frozen, resume correctly. Async rst_n_i low mid-stream -> all outputs 0 at once. Force counter to all-ones -> a further stall keeps all-ones.
